// File: rtl/bf_seq_if.sv
// Control and address bus between the FFT butterfly sequencer and its host / sample memory.
// The sequencer side uses the slave modport; the host side uses master.
interface bf_seq_if #(
  parameter int LOG2N = 7,
  parameter int SW    = 3
);
  logic             start;
  logic             busy;
  logic             done;
  logic [SW-1:0]    stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_up;
  logic [LOG2N-1:0] rd_addr_dn;
  logic [LOG2N-2:0] tw_addr;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_up;
  logic [LOG2N-1:0] wr_addr_dn;

  modport master (
    output start,
    input  busy, done, stage, rd_en, rd_addr_up, rd_addr_dn, tw_addr,
    input  wr_en, wr_addr_up, wr_addr_dn
  );

  modport slave (
    input  start,
    output busy, done, stage, rd_en, rd_addr_up, rd_addr_dn, tw_addr,
    output wr_en, wr_addr_up, wr_addr_dn
  );
endinterface

// File: rtl/bf_seq_ctrl.sv
// Address/control sequencer for an in-place radix-2 DIF FFT sharing one butterfly datapath.
// Write-back addresses are the read addresses delayed by the datapath latency.
module bf_seq_ctrl #(
  parameter int NPOINTS  = 128,
  parameter int LOG2N    = 7,
  parameter int PIPE_LAT = 3,
  parameter int SW       = 3
) (
  input  logic    clk,
  input  logic    rst,
  bf_seq_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one butterfly read pair issued per cycle
  // DRAIN | reads paused while the stage tail is written back
  // FIN   | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam int KW = LOG2N - 1;
  localparam int CW = $clog2(PIPE_LAT + 1);
  localparam int DW = 2 * LOG2N + 1;
  localparam logic [KW-1:0]    K_LAST = KW'(NPOINTS / 2 - 1);
  localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
  localparam logic [CW-1:0]    C_LOAD = CW'(PIPE_LAT);
  localparam logic [LOG2N-1:0] HALF   = LOG2N'(NPOINTS / 2);

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [SW-1:0]           stage_q, stage_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    rd_en_q, rd_en_d;
  logic [LOG2N-1:0]        up_q, up_d;
  logic [LOG2N-1:0]        dn_q, dn_d;
  logic [KW-1:0]           tw_q, tw_d;
  logic [PIPE_LAT-1:0][DW-1:0] dly_q, dly_d;

  logic [LOG2N-1:0] span, mask, k_ext, up;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          k_d     = '0;
          stage_d = '0;
        end
      end
      RUN: begin
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          cnt_d   = C_LOAD;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (stage_q == S_LAST) begin
            state_d = FIN;
          end else begin
            state_d = RUN;
            stage_d = stage_q + SW'(1);
            k_d     = '0;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with state_q.
  // The upper address is k with a zero inserted at the span bit.
  always_comb begin
    span    = HALF >> stage_d;
    mask    = span - LOG2N'(1);
    k_ext   = {1'b0, k_d};
    up      = ((k_ext & ~mask) << 1) | (k_ext & mask);
    rd_en_d = (state_d == RUN);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FIN);
    up_d    = rd_en_d ? up : '0;
    dn_d    = rd_en_d ? (up | span) : '0;
    tw_d    = rd_en_d ? ((k_d & mask[KW-1:0]) << stage_d) : '0;
  end

  always_comb begin
    dly_d    = '0;
    dly_d[0] = {rd_en_q, up_q, dn_q};
    for (int i = 1; i < PIPE_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      up_q    <= '0;
      dn_q    <= '0;
      tw_q    <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      tw_q    <= tw_d;
      dly_q   <= dly_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.stage      = stage_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr_up = up_q;
  assign bus.rd_addr_dn = dn_q;
  assign bus.tw_addr    = tw_q;
  assign {bus.wr_en, bus.wr_addr_up, bus.wr_addr_dn} = dly_q[PIPE_LAT-1];

endmodule
